// File: rtl/reg_file_mp.sv
// Multi-port CPU register file: two write ports (B has priority), NUM_RD combinational
// read ports with optional write bypass, optional hardwired zero register and busy scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     bsy_set_en,
  input  logic [ADDR_W-1:0]        bsy_set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int NUM_REG = 2 ** ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [DATA_W-1:0]  regs_reg [NUM_REG];
  logic [NUM_REG-1:0] busy_reg;

  logic wa_ok, wb_ok, set_ok;
  assign wa_ok  = wa_en && !(HAS_ZERO && (wa_addr == '0));
  assign wb_ok  = wb_en && !(HAS_ZERO && (wb_addr == '0));
  assign set_ok = bsy_set_en && !(HAS_ZERO && (bsy_set_addr == '0));

  // Statement order encodes priority: B overwrites A, and a set overrides any clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      if (wa_ok) begin
        regs_reg[wa_addr] <= wa_data;
        busy_reg[wa_addr] <= 1'b0;
      end
      if (wb_ok) begin
        regs_reg[wb_addr] <= wb_data;
        busy_reg[wb_addr] <= 1'b0;
      end
      if (set_ok) begin
        busy_reg[bsy_set_addr] <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit_a, hit_b, hit_set, is_zero;
      logic [DATA_W-1:0] data_next;
      logic              busy_next;

      assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign hit_a   = HAS_BYP && wa_en && (wa_addr == addr);
      assign hit_b   = HAS_BYP && wb_en && (wb_addr == addr);
      assign hit_set = bsy_set_en && (bsy_set_addr == addr);
      assign is_zero = HAS_ZERO && (addr == '0);

      always_comb begin
        data_next = regs_reg[addr];
        busy_next = busy_reg[addr];
        if (hit_a) begin
          data_next = wa_data;
        end
        if (hit_b) begin
          data_next = wb_data;
        end
        // A write landing this cycle retires the producer unless a newer one claims it.
        if ((hit_a || hit_b) && !hit_set) begin
          busy_next = 1'b0;
        end
        if (is_zero || !rst_n) begin
          data_next = '0;
          busy_next = 1'b0;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_next;
      assign rd_busy[gi]                  = busy_next;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a bypassing and a non-bypassing instance share all
// inputs; expected read results are queued when stimulus is driven and drained each cycle.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wa_en, wb_en, bsy_set_en;
  logic [AW-1:0] wa_addr, wb_addr, bsy_set_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0]    rd_busy, rd_busy_nb;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb)
  );

  typedef struct {
    string   tag;
    int      port;
    bit      nb;
    logic [DW-1:0] data;
    logic    busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void push(string tag, int port, bit nb, logic [DW-1:0] d, logic b);
    exp_t e;
    e.tag = tag; e.port = port; e.nb = nb; e.data = d; e.busy = b;
    sb.push_back(e);
  endfunction

  function automatic void expect_all(string tag, logic [DW-1:0] d_byp, logic b_byp,
                                     logic [DW-1:0] d_nb, logic b_nb);
    for (int p = 0; p < NR; p++) begin
      push(tag, p, 1'b0, d_byp, b_byp);
      push(tag, p, 1'b1, d_nb, b_nb);
    end
  endfunction

  task automatic idle();
    rst_n = 1'b1;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    bsy_set_en = 1'b0; bsy_set_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      set_rd(5'd5, 5'd5, 5'd5, 5'd5);
      case (c)
        0: begin rst_n = 1'b0; expect_all("rst_hold", 0, 0, 0, 0); end
        1: expect_all("rst_clear", 0, 0, 0, 0);
        2: begin
          wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
          expect_all("rst_prewrite", 32'hDEADBEEF, 0, 0, 0);
        end
        3: expect_all("rst_loaded", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        4: begin
          rst_n = 1'b0;
          set_rd(5'd5, 5'd6, 5'd5, 5'd6);
          wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h12345678;
          wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
          bsy_set_en = 1'b1; bsy_set_addr = 5'd6;
          expect_all("rst_gated", 0, 0, 0, 0);
        end
        default: begin
          set_rd(5'd5, 5'd6, 5'd5, 5'd6);
          expect_all("rst_after", 0, 0, 0, 0);
        end
      endcase
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [DW-1:0] ad;
        logic ab;
        e  = sb.pop_front();
        ad = e.nb ? rd_data_nb[e.port*DW +: DW] : rd_data[e.port*DW +: DW];
        ab = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
        checks++;
        if (ad !== e.data || ab !== e.busy) begin
          errors++;
          $display("FAIL %s p%0d nb=%0d: data=%h busy=%b want data=%h busy=%b",
                   e.tag, e.port, e.nb, ad, ab, e.data, e.busy);
        end else $display("ok   %s p%0d nb=%0d data=%h busy=%b", e.tag, e.port, e.nb, ad, ab);
      end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    for (int c = 0; c < 2; c++) begin
      idle();
      set_rd(5'd0, 5'd0, 5'd0, 5'd0);
      if (c == 0) begin
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        bsy_set_en = 1'b1; bsy_set_addr = 5'd0;
        expect_all("zero_same", 0, 0, 0, 0);
      end else expect_all("zero_next", 0, 0, 0, 0);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [DW-1:0] ad;
        logic ab;
        e  = sb.pop_front();
        ad = e.nb ? rd_data_nb[e.port*DW +: DW] : rd_data[e.port*DW +: DW];
        ab = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
        checks++;
        if (ad !== e.data || ab !== e.busy) begin
          errors++;
          $display("FAIL %s p%0d nb=%0d: data=%h busy=%b want data=%h busy=%b",
                   e.tag, e.port, e.nb, ad, ab, e.data, e.busy);
        end else $display("ok   %s p%0d nb=%0d data=%h busy=%b", e.tag, e.port, e.nb, ad, ab);
      end
      tick();
    end
  endtask

  task automatic test_collision_bypass();
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: begin
          set_rd(5'd7, 5'd7, 5'd7, 5'd7);
          wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
          wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
          expect_all("coll_same", 32'h22222222, 0, 0, 0);
        end
        1: begin
          set_rd(5'd7, 5'd7, 5'd7, 5'd7);
          expect_all("coll_next", 32'h22222222, 0, 32'h22222222, 0);
        end
        2: begin
          set_rd(5'd3, 5'd3, 5'd3, 5'd3);
          wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
          expect_all("byp_load", 32'hA5A5A5A5, 0, 0, 0);
        end
        3: begin
          set_rd(5'd3, 5'd3, 5'd3, 5'd3);
          wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h5A5A5A5A;
          expect_all("byp_same", 32'h5A5A5A5A, 0, 32'hA5A5A5A5, 0);
        end
        default: begin
          set_rd(5'd3, 5'd3, 5'd3, 5'd3);
          expect_all("byp_next", 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0);
        end
      endcase
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [DW-1:0] ad;
        logic ab;
        e  = sb.pop_front();
        ad = e.nb ? rd_data_nb[e.port*DW +: DW] : rd_data[e.port*DW +: DW];
        ab = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
        checks++;
        if (ad !== e.data || ab !== e.busy) begin
          errors++;
          $display("FAIL %s p%0d nb=%0d: data=%h busy=%b want data=%h busy=%b",
                   e.tag, e.port, e.nb, ad, ab, e.data, e.busy);
        end else $display("ok   %s p%0d nb=%0d data=%h busy=%b", e.tag, e.port, e.nb, ad, ab);
      end
      tick();
    end
  endtask

  task automatic test_scoreboard();
    for (int c = 0; c < 9; c++) begin
      idle();
      set_rd(5'd9, 5'd9, 5'd9, 5'd9);
      case (c)
        0: begin bsy_set_en = 1'b1; bsy_set_addr = 5'd9; expect_all("sb_set", 0, 0, 0, 0); end
        1: expect_all("sb_busy1", 0, 1, 0, 1);
        2: begin
          wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h99;
          expect_all("sb_wr", 32'h99, 0, 0, 1);
        end
        3: expect_all("sb_clear", 32'h99, 0, 32'h99, 0);
        4: begin bsy_set_en = 1'b1; bsy_set_addr = 5'd9; expect_all("sb_set2", 32'h99, 0, 32'h99, 0); end
        5: begin
          bsy_set_en = 1'b1; bsy_set_addr = 5'd9;
          wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
          expect_all("sb_race", 32'h77, 1, 32'h99, 1);
        end
        6: expect_all("sb_race_next", 32'h77, 1, 32'h77, 1);
        7: begin
          wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h78;
          expect_all("sb_wr2", 32'h78, 0, 32'h77, 1);
        end
        default: expect_all("sb_clear2", 32'h78, 0, 32'h78, 0);
      endcase
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [DW-1:0] ad;
        logic ab;
        e  = sb.pop_front();
        ad = e.nb ? rd_data_nb[e.port*DW +: DW] : rd_data[e.port*DW +: DW];
        ab = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
        checks++;
        if (ad !== e.data || ab !== e.busy) begin
          errors++;
          $display("FAIL %s p%0d nb=%0d: data=%h busy=%b want data=%h busy=%b",
                   e.tag, e.port, e.nb, ad, ab, e.data, e.busy);
        end else $display("ok   %s p%0d nb=%0d data=%h busy=%b", e.tag, e.port, e.nb, ad, ab);
      end
      tick();
    end
  endtask

  task automatic test_multiport();
    logic [DW-1:0] v1, v2, v31;
    logic [DW-1:0] want [NR];
    v1  = $urandom();
    v2  = v1 ^ 32'h0000_0001;
    v31 = v1 ^ 32'h8000_0000;
    want[0] = v1; want[1] = v2; want[2] = v1; want[3] = v31;
    for (int c = 0; c < 3; c++) begin
      idle();
      set_rd(5'd1, 5'd2, 5'd1, 5'd31);
      case (c)
        0: begin
          wa_en = 1'b1; wa_addr = 5'd1; wa_data = v1;
          wb_en = 1'b1; wb_addr = 5'd2; wb_data = v2;
        end
        1: begin wa_en = 1'b1; wa_addr = 5'd31; wa_data = v31; end
        default: begin
          for (int p = 0; p < NR; p++) begin
            push("multi", p, 1'b0, want[p], 0);
            push("multi", p, 1'b1, want[p], 0);
          end
        end
      endcase
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [DW-1:0] ad;
        logic ab;
        e  = sb.pop_front();
        ad = e.nb ? rd_data_nb[e.port*DW +: DW] : rd_data[e.port*DW +: DW];
        ab = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
        checks++;
        if (ad !== e.data || ab !== e.busy) begin
          errors++;
          $display("FAIL %s p%0d nb=%0d: data=%h busy=%b want data=%h busy=%b",
                   e.tag, e.port, e.nb, ad, ab, e.data, e.busy);
        end else $display("ok   %s p%0d nb=%0d data=%h busy=%b", e.tag, e.port, e.nb, ad, ab);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] mem_m [32];
    logic [31:0]   busy_m;
    logic [AW-1:0] a;
    logic          hit_w, hit_s;
    logic [DW-1:0] d_byp;
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    busy_m = '0;
    idle();
    rst_n = 1'b0;
    tick();
    for (int c = 0; c < 40; c++) begin
      idle();
      wa_en = 1'($urandom_range(0, 1)); wa_addr = AW'($urandom_range(0, 7)); wa_data = $urandom();
      wb_en = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom();
      bsy_set_en = 1'($urandom_range(0, 1)); bsy_set_addr = AW'($urandom_range(0, 7));
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      for (int p = 0; p < NR; p++) begin
        a     = rd_addr[p*AW +: AW];
        hit_w = (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
        hit_s = bsy_set_en && bsy_set_addr == a;
        if (wb_en && wb_addr == a) d_byp = wb_data;
        else if (wa_en && wa_addr == a) d_byp = wa_data;
        else d_byp = mem_m[a];
        if (a == '0) begin
          push("b2b", p, 1'b0, 0, 0);
          push("b2b", p, 1'b1, 0, 0);
        end else begin
          push("b2b", p, 1'b0, d_byp, busy_m[a] && !(hit_w && !hit_s));
          push("b2b", p, 1'b1, mem_m[a], busy_m[a]);
        end
      end
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [DW-1:0] ad;
        logic ab;
        e  = sb.pop_front();
        ad = e.nb ? rd_data_nb[e.port*DW +: DW] : rd_data[e.port*DW +: DW];
        ab = e.nb ? rd_busy_nb[e.port] : rd_busy[e.port];
        checks++;
        if (ad !== e.data || ab !== e.busy) begin
          errors++;
          $display("FAIL %s c%0d p%0d nb=%0d: data=%h busy=%b want data=%h busy=%b",
                   e.tag, c, e.port, e.nb, ad, ab, e.data, e.busy);
        end else $display("ok   %s c%0d p%0d nb=%0d data=%h busy=%b", e.tag, c, e.port, e.nb, ad, ab);
      end
      if (wa_en && wa_addr != '0) begin mem_m[wa_addr] = wa_data; busy_m[wa_addr] = 1'b0; end
      if (wb_en && wb_addr != '0) begin mem_m[wb_addr] = wb_data; busy_m[wb_addr] = 1'b0; end
      if (bsy_set_en && bsy_set_addr != '0) busy_m[bsy_set_addr] = 1'b1;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n   = 1'b0;
    rd_addr = '0;
    tick();
    test_reset();
    test_zero_reg();
    test_collision_bypass();
    test_scoreboard();
    test_multiport();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
